wb_retire_queue: RTL and testbench
==================================

# wb_retire_queue

Parametrised write-back/retire stage for the in-order NPC pipeline. It sits after MEM and replaces the single-entry write-back register with a DEPTH-entry in-order queue, so loads whose data returns late no longer block MEM hand-off. Entries retire one per cycle in program order, driving the register-file write port, the commit trace, and precise exception flush, with load data aligned and extended at retire.

## Interface
- XLEN, 64: datapath width (32 or 64).
- DEPTH, 4: queue entries, power of two, ≥2.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on clk edge).
- mem_to_wb_valid  in  1  MEM offers an entry.
- wb_allow_in  out  1  entry accepted this cycle when both high.
- mem_pc  in  XLEN; mem_inst  in  32; mem_rd  in  5; mem_rd_wen  in  1; mem_exe_result  in  XLEN.
- mem_ld  in  1  entry is a load; mem_ld_size  in  2  0=B,1=H,2=W,3=D (D only if XLEN=64); mem_ld_unsigned  in  1; mem_ld_off  in  3  byte offset within XLEN word.
- mem_ex  in  1  entry raises exception; mem_ecode  in  XLEN-1.
- ld_resp_valid  in  1; ld_resp_data  in  XLEN  raw aligned word, in load order.
- rf_wen  out  1; rf_waddr  out  5; rf_wdata  out  XLEN  register-file write port.
- retire_valid  out  1; retire_pc  out  XLEN; retire_inst  out  32  commit trace.
- ex_valid  out  1; ex_epc  out  XLEN; ex_ecode  out  XLEN-1  one-cycle exception/flush pulse.
- q_rs1, q_rs2  in  5 each; rs1_busy, rs2_busy  out  1 each  hazard query.

## Operation
- Circular queue: head, tail pointers (log2 DEPTH bits, wrap), count (log2 DEPTH + 1 bits). Per entry: payload fields, dready bit, data XLEN.
- wb_allow_in = rst & (count != DEPTH) & ~ex_valid. No enqueue-on-full even if head retires same cycle.
- Enqueue: write entry at tail, dready=0, tail+1.
- Load capture: ld_resp_valid with drop_cnt==0 writes ld_resp_data into the oldest valid entry (searched from head) with ld=1 & dready=0, sets dready. A response with no such entry is a protocol error (never occurs by contract); response never targets an entry enqueued in the same cycle.
- Head retirable when head valid and (ld==0 or dready==1).
- Normal retire (ex=0): retire_valid=1, retire_pc/inst from head; rf_wen = rd_wen & (rd!=0); rf_waddr=rd; rf_wdata = load ? extend(data) : exe_result; head+1, count−1.
- Load extend: byte lane = data >> (8*ld_off); take 8/16/32/64 bits; sign-extend unless unsigned. Misaligned offsets are MEM's responsibility (ex=1).
- Exception retire (ex=1): ex_valid=1, ex_epc=pc, ex_ecode=ecode; no rf write, retire_valid=0. Queue flushed: head=tail, count=0. drop_cnt <= (outstanding loads in queue incl. head) − (ld_resp_valid this cycle ? 1 : 0).
- drop_cnt (log2 DEPTH + 1 bits): while nonzero, each ld_resp_valid is discarded and decrements it.
- Hazard: rsN_busy = 1 if any valid entry has rd_wen & rd==q_rsN & rd!=0 (combinational over all entries, including the one retiring this cycle).
- Simultaneous enqueue+retire: count unchanged. Enqueue+capture+retire in one cycle all legal.

## Timing
- Reset (rst==0 at edge): head=tail=count=drop_cnt=0, all dready=0. Outputs while reset held and after: wb_allow_in=0 during reset then 1, rf_wen=0, retire_valid=0, ex_valid=0, rsN_busy=0; data outputs 0 when their valid is 0.
- Reset mid-operation discards all entries and pending drops immediately.
- Non-load entry accepted at edge N: retire outputs asserted in cycle N+1 (register file written at edge N+2) if it is head.
- Load: response captured at edge M; retires in cycle M+1 at earliest.
- Throughput: 1 retire/cycle sustained; full queue blocks MEM until a retire frees an entry (allow_in rises the cycle after).
- ex_valid is a single-cycle pulse; wb_allow_in=0 that cycle.

## Test plan
- Reset: hold rst=0 three cycles with mem_to_wb_valid=1 -> allow_in=0, no retire; release -> allow_in=1, count=0.
- ALU stream: 8 back-to-back entries rd=1..8, exe_result=0x10*i -> rf_wen each cycle from cycle after first accept, rf_wdata 0x10..0x80 in order, no stall.
- Late load: load rd=5, size=B, off=3, signed, then 3 ALU entries; response 0x0000_0000_8000_0000 seven cycles later -> queue fills, allow_in=0 at count=4; load retires with rf_wdata=0xFFFF_FFFF_FFFF_FF80, then ALU entries follow.
- Exception flush: entries ALU, ex=1 (pc=0x8000_0010, ecode=2), two loads -> ex_valid pulse with epc 0x8000_0010, two subsequent responses dropped, next new load captures the third response.
- Hazard/rd=0: entries rd=0 wen=1 and rd=7 -> q_rs1=0 busy=0, q_rs2=7 busy=1 until retire; rd=0 entry produces rf_wen=0.
- Wrap and simultaneous events: DEPTH=4, 20 mixed entries with response, enqueue and retire in the same cycle -> order preserved across pointer wrap, count never exceeds 4.

Source files
------------

// File: rtl/wb_retire_queue.sv
// In-order write-back/retire queue: buffers MEM results, captures late load data,
// retires one entry per cycle to the register file, commit trace and exception flush.
module wb_retire_queue #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_to_wb_valid,
    output logic              wb_allow_in,
    input  logic [XLEN-1:0]   mem_pc,
    input  logic [31:0]       mem_inst,
    input  logic [4:0]        mem_rd,
    input  logic              mem_rd_wen,
    input  logic [XLEN-1:0]   mem_exe_result,
    input  logic              mem_ld,
    input  logic [1:0]        mem_ld_size,
    input  logic              mem_ld_unsigned,
    input  logic [2:0]        mem_ld_off,
    input  logic              mem_ex,
    input  logic [XLEN-2:0]   mem_ecode,
    input  logic              ld_resp_valid,
    input  logic [XLEN-1:0]   ld_resp_data,
    output logic              rf_wen,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              retire_valid,
    output logic [XLEN-1:0]   retire_pc,
    output logic [31:0]       retire_inst,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_epc,
    output logic [XLEN-2:0]   ex_ecode,
    input  logic [4:0]        q_rs1,
    input  logic [4:0]        q_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [XLEN-1:0] exe_result;
        logic            ld;
        logic [1:0]      ld_size;
        logic            ld_unsigned;
        logic [2:0]      ld_off;
        logic            ex;
        logic [XLEN-2:0] ecode;
    } entry_t;

    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d, drop_cnt_q, drop_cnt_d;
    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] dready_q, dready_d;

    logic            rf_wen_q, rf_wen_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            retire_valid_q, retire_valid_d;
    logic [XLEN-1:0] retire_pc_q, retire_pc_d;
    logic [31:0]     retire_inst_q, retire_inst_d;
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_epc_q, ex_epc_d;
    logic [XLEN-2:0] ex_ecode_q, ex_ecode_d;

    logic [PW-1:0]   scan_idx, cap_idx, hz_idx;
    logic            cap_hit, head_rdy, enq, rs1_hit, rs2_hit;
    logic [CW-1:0]   outst;
    entry_t          head_ent;

    // Select the byte lane at the load offset, then zero/sign extend to XLEN.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                    input logic [1:0] size,
                                                    input logic uns,
                                                    input logic [2:0] off);
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] res;
        lane = raw >> {off, 3'b000};
        res  = lane;
        case (size)
            2'd0: begin
                if (uns) res = XLEN'(lane[7:0]);
                else     res = XLEN'($signed(lane[7:0]));
            end
            2'd1: begin
                if (uns) res = XLEN'(lane[15:0]);
                else     res = XLEN'($signed(lane[15:0]));
            end
            2'd2: begin
                if (uns) res = XLEN'(lane[31:0]);
                else     res = XLEN'($signed(lane[31:0]));
            end
            default: res = lane;
        endcase
        return res;
    endfunction

    assign wb_allow_in = rst & (count_q != CW'(DEPTH)) & ~ex_valid_q;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        drop_cnt_d     = drop_cnt_q;
        ent_d          = ent_q;
        data_d         = data_q;
        dready_d       = dready_q;
        rf_wen_d       = 1'b0;
        rf_waddr_d     = '0;
        rf_wdata_d     = '0;
        retire_valid_d = 1'b0;
        retire_pc_d    = '0;
        retire_inst_d  = '0;
        ex_valid_d     = 1'b0;
        ex_epc_d       = '0;
        ex_ecode_d     = '0;
        scan_idx       = '0;
        cap_idx        = '0;
        cap_hit        = 1'b0;
        outst          = '0;

        // Oldest load still waiting for data is the capture target.
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (CW'(i) < count_q && ent_q[scan_idx].ld && !dready_q[scan_idx]) begin
                outst = outst + CW'(1);
                if (!cap_hit) begin
                    cap_hit = 1'b1;
                    cap_idx = scan_idx;
                end
            end
        end

        head_ent = ent_q[head_q];
        head_rdy = (count_q != '0) && (!head_ent.ld || dready_q[head_q]);
        enq      = mem_to_wb_valid && wb_allow_in;

        if (enq) begin
            ent_d[tail_q].pc          = mem_pc;
            ent_d[tail_q].inst        = mem_inst;
            ent_d[tail_q].rd          = mem_rd;
            ent_d[tail_q].rd_wen      = mem_rd_wen;
            ent_d[tail_q].exe_result  = mem_exe_result;
            ent_d[tail_q].ld          = mem_ld;
            ent_d[tail_q].ld_size     = mem_ld_size;
            ent_d[tail_q].ld_unsigned = mem_ld_unsigned;
            ent_d[tail_q].ld_off      = mem_ld_off;
            ent_d[tail_q].ex          = mem_ex;
            ent_d[tail_q].ecode       = mem_ecode;
            dready_d[tail_q]          = 1'b0;
            tail_d                    = tail_q + PW'(1);
            count_d                   = count_d + CW'(1);
        end

        if (ld_resp_valid) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end else if (cap_hit) begin
                dready_d[cap_idx] = 1'b1;
                data_d[cap_idx]   = ld_resp_data;
            end
        end

        if (head_rdy) begin
            if (head_ent.ex) begin
                // Flush everything, including an entry arriving this cycle; its load reply is dropped too.
                ex_valid_d = 1'b1;
                ex_epc_d   = head_ent.pc;
                ex_ecode_d = head_ent.ecode;
                head_d     = tail_d;
                count_d    = '0;
                drop_cnt_d = drop_cnt_q + outst + CW'(enq && mem_ld) - CW'(ld_resp_valid);
            end else begin
                retire_valid_d = 1'b1;
                retire_pc_d    = head_ent.pc;
                retire_inst_d  = head_ent.inst;
                if (head_ent.rd_wen && head_ent.rd != 5'd0) begin
                    rf_wen_d   = 1'b1;
                    rf_waddr_d = head_ent.rd;
                    rf_wdata_d = head_ent.ld
                               ? load_extend(data_q[head_q], head_ent.ld_size,
                                             head_ent.ld_unsigned, head_ent.ld_off)
                               : head_ent.exe_result;
                end
                head_d  = head_q + PW'(1);
                count_d = count_d - CW'(1);
            end
        end
    end

    // Hazard lookup across every live entry, head included.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        hz_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hz_idx = head_q + PW'(i);
            if (CW'(i) < count_q && ent_q[hz_idx].rd_wen && ent_q[hz_idx].rd != 5'd0) begin
                if (ent_q[hz_idx].rd == q_rs1) rs1_hit = 1'b1;
                if (ent_q[hz_idx].rd == q_rs2) rs2_hit = 1'b1;
            end
        end
    end

    assign rs1_busy = rst & rs1_hit;
    assign rs2_busy = rst & rs2_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            drop_cnt_q     <= '0;
            dready_q       <= '0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
            retire_inst_q  <= '0;
            ex_valid_q     <= 1'b0;
            ex_epc_q       <= '0;
            ex_ecode_q     <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            drop_cnt_q     <= drop_cnt_d;
            dready_q       <= dready_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            retire_valid_q <= retire_valid_d;
            retire_pc_q    <= retire_pc_d;
            retire_inst_q  <= retire_inst_d;
            ex_valid_q     <= ex_valid_d;
            ex_epc_q       <= ex_epc_d;
            ex_ecode_q     <= ex_ecode_d;
        end
    end

    // Payload storage is qualified by count/dready, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_q  <= ent_d;
        data_q <= data_d;
    end

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_valid = retire_valid_q;
    assign retire_pc    = retire_pc_q;
    assign retire_inst  = retire_inst_q;
    assign ex_valid     = ex_valid_q;
    assign ex_epc       = ex_epc_q;
    assign ex_ecode     = ex_ecode_q;

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue: retirements are checked in order against
// hand-written expectations, with inline checks for timing, flush and hazards.
module tb_wb_retire_queue;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_to_wb_valid;
    logic            wb_allow_in;
    logic [63:0]     mem_pc;
    logic [31:0]     mem_inst;
    logic [4:0]      mem_rd;
    logic            mem_rd_wen;
    logic [63:0]     mem_exe_result;
    logic            mem_ld;
    logic [1:0]      mem_ld_size;
    logic            mem_ld_unsigned;
    logic [2:0]      mem_ld_off;
    logic            mem_ex;
    logic [62:0]     mem_ecode;
    logic            ld_resp_valid;
    logic [63:0]     ld_resp_data;
    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [63:0]     rf_wdata;
    logic            retire_valid;
    logic [63:0]     retire_pc;
    logic [31:0]     retire_inst;
    logic            ex_valid;
    logic [63:0]     ex_epc;
    logic [62:0]     ex_ecode;
    logic [4:0]      q_rs1;
    logic [4:0]      q_rs2;
    logic            rs1_busy;
    logic            rs2_busy;

    always #5 clk = ~clk;

    wb_retire_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_to_wb_valid(mem_to_wb_valid), .wb_allow_in(wb_allow_in),
        .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rd(mem_rd), .mem_rd_wen(mem_rd_wen),
        .mem_exe_result(mem_exe_result), .mem_ld(mem_ld), .mem_ld_size(mem_ld_size),
        .mem_ld_unsigned(mem_ld_unsigned), .mem_ld_off(mem_ld_off),
        .mem_ex(mem_ex), .mem_ecode(mem_ecode),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_inst(retire_inst),
        .ex_valid(ex_valid), .ex_epc(ex_epc), .ex_ecode(ex_ecode),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   acc_cnt  = 0;
    int   ret_cnt  = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_ret(input logic [63:0] pc, input logic wen, input logic [4:0] rd,
                              input logic [63:0] wdata);
        exp_t e;
        e.pc = pc; e.inst = inst_of(pc); e.wen = wen; e.rd = rd; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    // One clock; response pulses are consumed, and any retirement is matched in order.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        ld_resp_valid = 1'b0;
        if (retire_valid === 1'b1 || ex_valid === 1'b1) ret_cnt++;
        if (retire_valid === 1'b1 || rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ret_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("ret_valid", 64'(retire_valid), 64'd1);
                check("ret_pc", retire_pc, e.pc);
                check("ret_inst", 64'(retire_inst), 64'(e.inst));
                check("ret_wen", 64'(rf_wen), 64'(e.wen));
                check("ret_waddr", 64'(rf_waddr), 64'(e.rd));
                check("ret_wdata", rf_wdata, e.wdata);
            end
        end
    endtask

    task automatic send(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                        input logic [63:0] res, input logic ld, input logic [1:0] sz,
                        input logic uns, input logic [2:0] off, input logic ex,
                        input logic [62:0] ecode);
        logic acc_ok;
        mem_pc = pc; mem_inst = inst_of(pc); mem_rd = rd; mem_rd_wen = wen;
        mem_exe_result = res; mem_ld = ld; mem_ld_size = sz; mem_ld_unsigned = uns;
        mem_ld_off = off; mem_ex = ex; mem_ecode = ecode;
        mem_to_wb_valid = 1'b1;
        acc_ok = 1'b0;
        for (int k = 0; k < 40 && !acc_ok; k++) begin
            acc_ok = wb_allow_in;
            step();
        end
        check("send_accept", 64'(acc_ok), 64'd1);
        if (acc_ok) acc_cnt++;
        mem_to_wb_valid = 1'b0;
    endtask

    task automatic alu(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] res);
        send(pc, rd, 1'b1, res, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 63'd0);
    endtask

    task automatic load(input logic [63:0] pc, input logic [4:0] rd, input logic [1:0] sz,
                        input logic uns, input logic [2:0] off);
        send(pc, rd, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, sz, uns, off, 1'b0, 63'd0);
    endtask

    task automatic resp(input logic [63:0] data);
        ld_resp_valid = 1'b1;
        ld_resp_data  = data;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_ld;
        int          prev_i;
        logic        is_ld;
        logic [63:0] pc;

        rst = 1'b0; mem_to_wb_valid = 1'b1; mem_pc = 64'h9000; mem_inst = 32'h13;
        mem_rd = 5'd1; mem_rd_wen = 1'b1; mem_exe_result = 64'h1; mem_ld = 1'b0;
        mem_ld_size = 2'd0; mem_ld_unsigned = 1'b0; mem_ld_off = 3'd0; mem_ex = 1'b0;
        mem_ecode = 63'd0; ld_resp_valid = 1'b0; ld_resp_data = 64'd0;
        q_rs1 = 5'd0; q_rs2 = 5'd0;

        // Reset held with MEM offering
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_allow", 64'(wb_allow_in), 64'd0);
            check("rst_retire", 64'(retire_valid), 64'd0);
            check("rst_wen", 64'(rf_wen), 64'd0);
            check("rst_ex", 64'(ex_valid), 64'd0);
        end
        mem_to_wb_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rel_allow", 64'(wb_allow_in), 64'd1);
        q_rs1 = 5'd1;
        #1;
        check("rst_rel_busy", 64'(rs1_busy), 64'd0);

        // Back-to-back ALU stream
        for (int i = 1; i <= 8; i++) expect_ret(64'h1000 + 64'(4 * i), 1'b1, 5'(i), 64'(16 * i));
        for (int i = 1; i <= 8; i++) begin
            check("alu_allow", 64'(wb_allow_in), 64'd1);
            alu(64'h1000 + 64'(4 * i), 5'(i), 64'(16 * i));
            if (i >= 2) check("alu_wen_cycle", 64'(rf_wen), 64'd1);
        end
        step();
        check("alu_last_wen", 64'(rf_wen), 64'd1);
        step();
        check("alu_idle_wen", 64'(rf_wen), 64'd0);
        drain(2);

        // Late load blocks the head until its response
        expect_ret(64'h6000, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80);
        expect_ret(64'h6004, 1'b1, 5'd1, 64'hA1);
        expect_ret(64'h6008, 1'b1, 5'd2, 64'hA2);
        expect_ret(64'h600C, 1'b1, 5'd3, 64'hA3);
        expect_ret(64'h6010, 1'b1, 5'd4, 64'hA4);
        load(64'h6000, 5'd5, 2'd0, 1'b0, 3'd3);
        alu(64'h6004, 5'd1, 64'hA1);
        alu(64'h6008, 5'd2, 64'hA2);
        alu(64'h600C, 5'd3, 64'hA3);
        check("full_allow", 64'(wb_allow_in), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("full_hold", 64'(wb_allow_in), 64'd0);
        end
        resp(64'h0000_0000_8000_0000);
        step();
        check("late_no_early", 64'(rf_wen), 64'd0);
        step();
        check("late_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("late_allow_rise", 64'(wb_allow_in), 64'd1);
        alu(64'h6010, 5'd4, 64'hA4);
        drain(6);

        // Exception flush with two outstanding loads behind it
        expect_ret(64'h2000, 1'b1, 5'd3, 64'h33);
        expect_ret(64'h2004, 1'b1, 5'd4, 64'h0000_0000_9ABC_DEF0);
        expect_ret(64'h2010, 1'b1, 5'd12, 64'hCAFE_F00D_0000_0001);
        alu(64'h2000, 5'd3, 64'h33);
        load(64'h2004, 5'd4, 2'd2, 1'b1, 3'd0);
        send(64'h8000_0010, 5'd9, 1'b1, 64'h99, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 63'd2);
        load(64'h2008, 5'd10, 2'd3, 1'b0, 3'd0);
        load(64'h200C, 5'd11, 2'd3, 1'b0, 3'd0);
        resp(64'h1234_5678_9ABC_DEF0);
        step();
        step();
        step();
        check("ex_valid", 64'(ex_valid), 64'd1);
        check("ex_epc", ex_epc, 64'h8000_0010);
        check("ex_ecode", 64'(ex_ecode), 64'd2);
        check("ex_no_retire", 64'(retire_valid), 64'd0);
        check("ex_no_wen", 64'(rf_wen), 64'd0);
        check("ex_allow", 64'(wb_allow_in), 64'd0);
        step();
        check("ex_pulse", 64'(ex_valid), 64'd0);
        check("ex_epc_idle", ex_epc, 64'd0);
        check("ex_allow_back", 64'(wb_allow_in), 64'd1);
        load(64'h2010, 5'd12, 2'd3, 1'b0, 3'd0);
        resp(64'h0000_0000_0000_1111);
        step();
        resp(64'h0000_0000_0000_2222);
        step();
        resp(64'hCAFE_F00D_0000_0001);
        step();
        drain(3);

        // Hazard lookup and rd=0 write suppression
        expect_ret(64'h3000, 1'b1, 5'd2, 64'hFFFF_FFFF_FFFF_ABCD);
        expect_ret(64'h3004, 1'b0, 5'd0, 64'd0);
        expect_ret(64'h3008, 1'b1, 5'd7, 64'h77);
        load(64'h3000, 5'd2, 2'd1, 1'b0, 3'd2);
        alu(64'h3004, 5'd0, 64'h55);
        alu(64'h3008, 5'd7, 64'h77);
        q_rs1 = 5'd0; q_rs2 = 5'd7;
        #1;
        check("hz_rd0", 64'(rs1_busy), 64'd0);
        check("hz_rd7", 64'(rs2_busy), 64'd1);
        q_rs1 = 5'd2; q_rs2 = 5'd9;
        #1;
        check("hz_load_rd", 64'(rs1_busy), 64'd1);
        check("hz_absent", 64'(rs2_busy), 64'd0);
        q_rs2 = 5'd7;
        resp(64'h0000_0000_ABCD_0000);
        step();
        step();
        check("hz_load_gone", 64'(rs1_busy), 64'd0);
        check("hz_rd7_held", 64'(rs2_busy), 64'd1);
        step();
        check("hz_rd7_head", 64'(rs2_busy), 64'd1);
        step();
        check("hz_rd7_clear", 64'(rs2_busy), 64'd0);
        drain(2);

        // Pointer wrap with capture, enqueue and retire overlapping
        acc_cnt = 0;
        ret_cnt = 0;
        prev_ld = 1'b0;
        prev_i  = 0;
        for (int i = 0; i < 20; i++) begin
            is_ld = (i % 3 == 1);
            pc    = 64'h4000 + 64'(4 * i);
            if (prev_ld) resp(64'hD000 + 64'(prev_i));
            expect_ret(pc, 1'b1, 5'(i + 1), is_ld ? 64'hD000 + 64'(i) : 64'h100 + 64'(i));
            if (is_ld) load(pc, 5'(i + 1), 2'd3, 1'b0, 3'd0);
            else       alu(pc, 5'(i + 1), 64'h100 + 64'(i));
            check("wrap_occ", 64'((acc_cnt - ret_cnt) <= 4), 64'd1);
            prev_ld = is_ld;
            prev_i  = i;
        end
        if (prev_ld) resp(64'hD000 + 64'(prev_i));
        drain(8);

        // Reset mid-operation discards a blocked load
        load(64'h5000, 5'd6, 2'd3, 1'b0, 3'd0);
        q_rs1 = 5'd6;
        #1;
        check("mid_busy", 64'(rs1_busy), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("mid_busy_clr", 64'(rs1_busy), 64'd0);
        check("mid_allow", 64'(wb_allow_in), 64'd1);
        expect_ret(64'h5004, 1'b1, 5'd7, 64'h77);
        alu(64'h5004, 5'd7, 64'h77);
        drain(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
